// File: rtl/cam_store.sv
// Storage and write stage of the 8x4 CAM: entry array, valid bits, occupancy.
// Supports direct write, insert into lowest free slot, and delete by address.
module cam_store #(
    parameter int ENTRIES = 8,
    parameter int WIDTH   = 4,
    parameter int AW      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             ins_en,
    input  logic             del_en,
    input  logic [AW-1:0]    del_addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q [ENTRIES-1:0],
    output logic [ENTRIES-1:0] vld,
    output logic [AW-1:0]    free_addr,
    output logic             ins_ack,
    output logic [AW-1:0]    ins_addr,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    logic [WIDTH-1:0]   mem_q [ENTRIES-1:0];
    logic [WIDTH-1:0]   mem_d [ENTRIES-1:0];
    logic [ENTRIES-1:0] vld_q, vld_d;
    logic [AW:0]        count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               ins_ack_q, ins_ack_d;
    logic [AW-1:0]      ins_addr_q, ins_addr_d;
    logic               ovf_q, ovf_d;
    logic               all_valid;

    // Lowest invalid index; descending scan so the lowest match is written last.
    always_comb begin
        free_addr = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (!vld_q[i-1]) free_addr = AW'(i - 1);
        end
    end

    assign all_valid = &vld_q;

    // Delete is applied first so a same-address write overrides it; insert
    // targets free_addr from the current vld, so a slot freed now is not reused.
    always_comb begin
        mem_d      = mem_q;
        vld_d      = vld_q;
        ins_ack_d  = 1'b0;
        ovf_d      = 1'b0;
        ins_addr_d = ins_addr_q;

        if (del_en) vld_d[del_addr] = 1'b0;

        if (wr_en) begin
            mem_d[wr_addr] = din;
            vld_d[wr_addr] = 1'b1;
        end else if (ins_en) begin
            if (!all_valid) begin
                mem_d[free_addr] = din;
                vld_d[free_addr] = 1'b1;
                ins_ack_d        = 1'b1;
                ins_addr_d       = free_addr;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Popcount of the next valid vector equals count + set - clr.
        count_d = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            count_d = count_d + {{AW{1'b0}}, vld_d[i]};
        end
        full_d  = (count_d == (AW+1)'(ENTRIES));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
            vld_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ins_ack_q  <= 1'b0;
            ins_addr_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            vld_q      <= vld_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ins_ack_q  <= ins_ack_d;
            ins_addr_q <= ins_addr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign q        = mem_q;
    assign vld      = vld_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign ins_ack  = ins_ack_q;
    assign ins_addr = ins_addr_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cam_store.sv
// Randomized and directed bench for cam_store against a behavioural model
// holding the entry array as plain arrays.
module tb_cam_store;

    logic       clk = 1'b0;
    logic       reset, wr_en, ins_en, del_en;
    logic [2:0] wr_addr, del_addr;
    logic [3:0] din;
    logic [3:0] q [7:0];
    logic [7:0] vld;
    logic [2:0] free_addr, ins_addr;
    logic       ins_ack, full, empty, ovf;
    logic [3:0] count;

    cam_store #(.ENTRIES(8), .WIDTH(4), .AW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .ins_en(ins_en), .del_en(del_en), .del_addr(del_addr), .din(din),
        .q(q), .vld(vld), .free_addr(free_addr), .ins_ack(ins_ack),
        .ins_addr(ins_addr), .count(count), .full(full), .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_data [8];
    bit         m_valid [8];
    int         m_ins_addr = 0;
    bit         m_ack = 0, m_ovf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        foreach (m_valid[i]) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        int free = m_free();
        bool_full: begin end
        m_ack = 0;
        m_ovf = 0;
        if (reset) begin
            foreach (m_data[i]) begin m_data[i] = 0; m_valid[i] = 0; end
            m_ins_addr = 0;
        end else begin
            bit was_full = (m_count() == 8);
            if (del_en) m_valid[del_addr] = 0;
            if (wr_en) begin
                m_data[wr_addr]  = din;
                m_valid[wr_addr] = 1;
            end else if (ins_en) begin
                if (was_full) m_ovf = 1;
                else begin
                    m_data[free] = din;
                    m_valid[free] = 1;
                    m_ack = 1;
                    m_ins_addr = free;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] got_q, exp_q;
        logic [7:0]  exp_v;
        for (int i = 0; i < 8; i++) begin
            got_q[i*4 +: 4] = q[i];
            exp_q[i*4 +: 4] = m_data[i];
            exp_v[i]        = m_valid[i];
        end
        check("q", got_q, exp_q);
        check("vld", {24'd0, vld}, {24'd0, exp_v});
        check("count", {28'd0, count}, m_count());
        check("full", {31'd0, full}, {31'd0, m_count() == 8});
        check("empty", {31'd0, empty}, {31'd0, m_count() == 0});
        check("ins_ack", {31'd0, ins_ack}, {31'd0, m_ack});
        check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        check("ins_addr", {29'd0, ins_addr}, m_ins_addr);
        check("free_addr", {29'd0, free_addr}, m_free());
    endtask

    task automatic op(input bit rs, input bit we, input int wa, input bit ie,
                      input bit de, input int da, input int d);
        reset = rs; wr_en = we; wr_addr = 3'(wa); ins_en = ie;
        del_en = de; del_addr = 3'(da); din = 4'(d);
        model_step();
        @(posedge clk);
        #1;
        check_all();
        reset = 0; wr_en = 0; ins_en = 0; del_en = 0;
    endtask

    initial begin
        foreach (m_data[i]) begin m_data[i] = 0; m_valid[i] = 0; end
        reset = 1; wr_en = 0; ins_en = 0; del_en = 0;
        wr_addr = 0; del_addr = 0; din = 0;

        op(1, 0, 0, 1, 0, 0, 0);
        check("reset_empty", {31'd0, empty}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            op(0, 0, 0, 1, 0, 0, i + 1);
            check("seq_ins_addr", {29'd0, ins_addr}, i);
        end
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_vld", {24'd0, vld}, 32'hFF);

        op(0, 0, 0, 1, 0, 0, 4'hA);
        check("ovf_full", {31'd0, ovf}, 32'd1);
        op(0, 0, 0, 1, 1, 3, 4'hB);
        check("ovf_del", {31'd0, ovf}, 32'd1);
        check("del_count", {28'd0, count}, 32'd7);
        op(0, 0, 0, 1, 0, 0, 4'hB);
        check("reuse_addr", {29'd0, ins_addr}, 32'd3);
        check("reuse_q3", {28'd0, q[3]}, 32'hB);

        op(1, 0, 0, 0, 0, 0, 0);
        op(0, 1, 5, 1, 0, 0, 4'h7);
        check("wr_vs_ins_vld", {24'd0, vld}, 32'h20);
        check("wr_vs_ins_ack", {31'd0, ins_ack}, 32'd0);
        op(0, 1, 2, 0, 1, 2, 4'h9);
        check("wr_del_vld", {24'd0, vld}, 32'h24);
        op(0, 0, 0, 0, 1, 6, 0);
        check("del_invalid", {28'd0, count}, 32'd2);

        op(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 0, 0, 1, 0, 0, i + 3);
        op(1, 0, 0, 1, 0, 0, 4'hF);
        check("midreset_count", {28'd0, count}, 32'd0);

        for (int n = 0; n < 500; n++) begin
            op($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
               $urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
